// File: rtl/ins_loader_16x9.sv
// ins_loader_16x9
// Write side of the 16:1 9-bit instruction mux. A start pulse opens a load,
// then 16 instruction words arrive over a valid/ready handshake and land in
// slots 0..15, which drive the mux inputs A..P directly.
//
// Optional feature: define INS_LOADER_CHECKSUM_EN to accept a 17th word after
// slot 15. That word is compared with the XOR of the 16 loaded words, and the
// result is reported on err. Without the macro, err is tied low and there is
// no CHECK state and no accumulator.
//
// Every output comes from a flop. din_ready is a registered function of the
// state, so no input reaches an output combinationally.

module ins_loader_16x9 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] DIN,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [8:0] A,
    output logic [8:0] B,
    output logic [8:0] C,
    output logic [8:0] D,
    output logic [8:0] E,
    output logic [8:0] F,
    output logic [8:0] G,
    output logic [8:0] H,
    output logic [8:0] I,
    output logic [8:0] J,
    output logic [8:0] K,
    output logic [8:0] L,
    output logic [8:0] M,
    output logic [8:0] N,
    output logic [8:0] O,
    output logic [8:0] P,
    output logic       sel3,
    output logic       sel2,
    output logic       sel1,
    output logic       sel0,
    output logic       done,
    output logic       err
);

`ifdef INS_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Fold one more word into the running XOR checksum.
    function automatic logic [8:0] csum_fold(input logic [8:0] acc, input logic [8:0] word);
        return acc ^ word;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

    state_t      state_r;
    logic [8:0]  slots_r [16];
    logic [3:0]  ptr_r;
    logic        din_ready_r;
    logic        done_r;
    logic        xfer_s;
`ifdef INS_LOADER_CHECKSUM_EN
    logic [8:0]  csum_r;
    logic        err_r;
`endif

    assign xfer_s = din_valid & din_ready_r;

    // Load controller: state, write pointer, slot storage and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 4'd0;
            din_ready_r <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                slots_r[i] <= 9'h000;
            end
`ifdef INS_LOADER_CHECKSUM_EN
            csum_r      <= 9'h000;
            err_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // Slot contents are kept; the new load overwrites them in order.
                    if (start) begin
                        state_r     <= ST_LOAD;
                        ptr_r       <= 4'd0;
                        din_ready_r <= 1'b1;
                        done_r      <= 1'b0;
`ifdef INS_LOADER_CHECKSUM_EN
                        csum_r      <= 9'h000;
                        err_r       <= 1'b0;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        slots_r[ptr_r] <= DIN;
                        ptr_r          <= ptr_r + 4'd1;
`ifdef INS_LOADER_CHECKSUM_EN
                        csum_r         <= csum_fold(csum_r, DIN);
                        if (ptr_r == 4'd15) begin
                            state_r <= ST_CHECK;
                        end else begin
                            state_r <= ST_LOAD;
                        end
`else
                        if (ptr_r == 4'd15) begin
                            state_r     <= ST_DONE;
                            din_ready_r <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            state_r <= ST_LOAD;
                        end
`endif
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
`ifdef INS_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    // The checksum word is compared only; it is never stored in a slot.
                    if (xfer_s) begin
                        err_r       <= (DIN != csum_r);
                        state_r     <= ST_DONE;
                        din_ready_r <= 1'b0;
                        done_r      <= 1'b1;
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
`endif
                default: begin
                    state_r     <= ST_IDLE;
                    din_ready_r <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready = din_ready_r;
    assign done      = done_r;
    assign sel3      = ptr_r[3];
    assign sel2      = ptr_r[2];
    assign sel1      = ptr_r[1];
    assign sel0      = ptr_r[0];

`ifdef INS_LOADER_CHECKSUM_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign A = slots_r[0];
    assign B = slots_r[1];
    assign C = slots_r[2];
    assign D = slots_r[3];
    assign E = slots_r[4];
    assign F = slots_r[5];
    assign G = slots_r[6];
    assign H = slots_r[7];
    assign I = slots_r[8];
    assign J = slots_r[9];
    assign K = slots_r[10];
    assign L = slots_r[11];
    assign M = slots_r[12];
    assign N = slots_r[13];
    assign O = slots_r[14];
    assign P = slots_r[15];

endmodule
